// File: rtl/fetch_pkg.sv
// Shared fetch types: the instruction-queue entry format, the fetch FSM
// state encoding and small pc helpers used by the fetch unit.
package fetch_pkg;

    // Instructions fetched per icache access (one 64-bit beat).
    localparam int FETCH_WIDTH = 2;

    // One instruction queue entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        PUSH = 2'd3
    } fetch_state_e;

    // Icache accesses are always made on an 8-byte boundary.
    function automatic logic [31:0] fetch_block_addr(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

    // Bytes consumed from a beat starting at pc: both words when pc sits on
    // the low half of the block, only the upper word otherwise.
    function automatic logic [31:0] fetch_pc_step(input logic [31:0] pc);
        return pc[2] ? 32'd4 : 32'd8;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one 8-byte icache request at a time,
// turns the returned beat into one or two instruction queue entries and
// follows branch/exception redirects, dropping stale responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              redirect_valid,
    input  logic [31:0]                       redirect_pc,
    output logic                              ic_req,
    output logic [31:0]                       ic_addr,
    input  logic                              ic_ack,
    input  logic                              ic_rvalid,
    input  logic [63:0]                       ic_rdata,
    output logic                              buf_ins_enable,
    output logic                              buf_new_count,
    output fetch_entry_t [FETCH_WIDTH-1:0]    buf_elements,
    input  logic                              buf_full
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         discard_reg, discard_next;
    logic [31:0]  hold_pc_reg, hold_pc_next;
    logic [63:0]  hold_data_reg, hold_data_next;

    // The address presented to the icache tracks pc continuously, so a
    // redirect while a request is still unacknowledged retargets it.
    assign ic_addr = fetch_block_addr(pc_reg);

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            discard_reg   <= 1'b0;
            hold_pc_reg   <= '0;
            hold_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            discard_reg   <= discard_next;
            hold_pc_reg   <= hold_pc_next;
            hold_data_reg <= hold_data_next;
        end
    end

    // Next-state logic, request strobe and push strobe.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        discard_next   = discard_reg;
        hold_pc_next   = hold_pc_reg;
        hold_data_next = hold_data_reg;
        ic_req         = 1'b0;
        buf_ins_enable = 1'b0;

        unique case (state_reg)
            IDLE: begin
                state_next = REQ;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
            end

            REQ: begin
                ic_req = 1'b1;
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                if (ic_ack) begin
                    // A redirect in the accept cycle makes the in-flight
                    // response stale before it even arrives.
                    state_next   = WAIT;
                    discard_next = redirect_valid;
                end
            end

            WAIT: begin
                if (ic_rvalid) begin
                    if (discard_reg || redirect_valid) begin
                        discard_next = 1'b0;
                        state_next   = REQ;
                        if (redirect_valid) begin
                            pc_next = redirect_pc;
                        end
                    end else begin
                        hold_pc_next   = pc_reg;
                        hold_data_next = ic_rdata;
                        state_next     = PUSH;
                    end
                end else if (redirect_valid) begin
                    pc_next      = redirect_pc;
                    discard_next = 1'b1;
                end
            end

            PUSH: begin
                buf_ins_enable = ~buf_full & ~redirect_valid;
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (!buf_full) begin
                    pc_next    = hold_pc_reg + fetch_pc_step(hold_pc_reg);
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Queue entries built from the held beat; unused slots read as zero.
    always_comb begin
        buf_new_count = 1'b0;
        buf_elements  = '0;
        if (state_reg == PUSH) begin
            if (hold_pc_reg[2]) begin
                buf_elements[0] = {hold_pc_reg, hold_data_reg[63:32]};
            end else begin
                buf_new_count   = 1'b1;
                buf_elements[0] = {hold_pc_reg, hold_data_reg[31:0]};
                buf_elements[1] = {hold_pc_reg + 32'd4, hold_data_reg[63:32]};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model of the
// fetch protocol is compared against the DUT every falling edge, and
// directed scenarios pin individual pushes to hand-computed values.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic                           clock = 1'b0;
    logic                           reset_n = 1'b0;
    logic                           redirect_valid = 1'b0;
    logic [31:0]                    redirect_pc = '0;
    logic                           ic_req;
    logic [31:0]                    ic_addr;
    logic                           ic_ack = 1'b0;
    logic                           ic_rvalid = 1'b0;
    logic [63:0]                    ic_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    logic                           buf_ins_enable;
    logic                           buf_new_count;
    fetch_entry_t [FETCH_WIDTH-1:0] buf_elements;
    logic                           buf_full = 1'b0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_ack         (ic_ack),
        .ic_rvalid      (ic_rvalid),
        .ic_rdata       (ic_rdata),
        .buf_ins_enable (buf_ins_enable),
        .buf_new_count  (buf_new_count),
        .buf_elements   (buf_elements),
        .buf_full       (buf_full)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model: pc, plus which phase of the fetch protocol we are in.
    logic [31:0] m_pc = RESET_PC;
    logic        m_idle = 1'b1;      // first cycle after reset
    logic        m_out = 1'b0;       // request accepted, response pending
    logic [31:0] m_req_pc = '0;
    logic        m_req_ok = 1'b0;    // response of outstanding request still wanted
    logic        m_pend = 1'b0;      // entries waiting to be pushed
    logic        m_pend_cnt = 1'b0;
    logic [63:0] m_pend_e0 = '0;
    logic [63:0] m_pend_e1 = '0;
    logic [31:0] m_next_pc;
    logic [31:0] m_blk;
    logic        exp_req, exp_en;

    // Pushes actually observed from the DUT.
    int          push_count = 0;
    logic        last_cnt = 1'b0;
    logic [63:0] last_e0 = '0;
    logic [63:0] last_e1 = '0;

    // Compare process: check outputs mid-cycle, then advance the model.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_ic_req", 64'(ic_req), 64'(1'b0));
                check("rst_ins_enable", 64'(buf_ins_enable), 64'(1'b0));
                check("rst_new_count", 64'(buf_new_count), 64'(1'b0));
                check("rst_elem0", 64'(buf_elements[0]), 64'd0);
                check("rst_elem1", 64'(buf_elements[1]), 64'd0);
                check("rst_ic_addr", 64'(ic_addr), 64'({RESET_PC[31:3], 3'b000}));
                m_pc     = RESET_PC;
                m_idle   = 1'b1;
                m_out    = 1'b0;
                m_req_ok = 1'b0;
                m_pend   = 1'b0;
            end else begin
                exp_req = !m_idle && !m_out && !m_pend;
                exp_en  = m_pend && !buf_full && !redirect_valid;
                check("ic_req", 64'(ic_req), 64'(exp_req));
                check("ic_addr", 64'(ic_addr), 64'({m_pc[31:3], 3'b000}));
                check("buf_ins_enable", 64'(buf_ins_enable), 64'(exp_en));
                if (m_pend) begin
                    check("buf_new_count", 64'(buf_new_count), 64'(m_pend_cnt));
                    check("buf_elem0", 64'(buf_elements[0]), m_pend_e0);
                    check("buf_elem1", 64'(buf_elements[1]), m_pend_e1);
                end
                if (buf_ins_enable) begin
                    push_count++;
                    last_cnt = buf_new_count;
                    last_e0  = buf_elements[0];
                    last_e1  = buf_elements[1];
                end

                m_next_pc = m_pc;
                if (m_idle) begin
                    m_idle = 1'b0;
                end else if (m_pend) begin
                    if (exp_en) begin
                        m_next_pc = m_pc + (m_pend_cnt ? 32'd8 : 32'd4);
                        m_pend    = 1'b0;
                    end else if (redirect_valid) begin
                        m_pend = 1'b0;
                    end
                end else if (m_out) begin
                    if (ic_rvalid) begin
                        m_out = 1'b0;
                        if (m_req_ok && !redirect_valid) begin
                            // Entries are the words from pc up to the block end.
                            m_blk      = {m_req_pc[31:3], 3'b000};
                            m_pend     = 1'b1;
                            m_pend_e1  = '0;
                            if (m_req_pc[2]) begin
                                m_pend_cnt = 1'b0;
                                m_pend_e0  = {m_req_pc, ic_rdata[63:32]};
                            end else begin
                                m_pend_cnt = 1'b1;
                                m_pend_e0  = {m_blk, ic_rdata[31:0]};
                                m_pend_e1  = {m_blk + 32'd4, ic_rdata[63:32]};
                            end
                        end
                    end else if (redirect_valid) begin
                        m_req_ok = 1'b0;
                    end
                end else if (ic_ack) begin
                    m_out    = 1'b1;
                    m_req_pc = m_pc;
                    m_req_ok = !redirect_valid;
                end
                if (redirect_valid) begin
                    m_next_pc = redirect_pc;
                end
                m_pc = m_next_pc;
            end
        end
    end

    // Stimulus helpers; inputs change just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!ic_req && n < 50) begin
            tick();
            n++;
        end
        check("wait_ic_req", 64'(ic_req), 64'(1'b1));
    endtask

    task automatic do_ack(input logic redir, input logic [31:0] rpc);
        wait_req();
        ic_ack         = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        tick();
        ic_ack         = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic do_rvalid(input logic [63:0] d);
        ic_rvalid = 1'b1;
        ic_rdata  = d;
        tick();
        ic_rvalid = 1'b0;
        ic_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic do_redirect(input logic [31:0] rpc);
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_push(input int start);
        int n = 0;
        while (push_count == start && n < 30) begin
            tick();
            n++;
        end
        check("push_seen", 64'(push_count != start), 64'(1'b1));
    endtask

    int pc0;

    initial begin
        // Reset held for a few cycles.
        repeat (3) tick();
        check("lit_rst_addr", 64'(ic_addr), 64'h0000_0000_BFC0_0000);
        reset_n = 1'b1;

        // Straight-line fetch from the reset vector.
        pc0 = push_count;
        do_ack(1'b0, 32'h0);
        do_rvalid(64'h1111_2222_3333_4444);
        wait_push(pc0);
        check("lit_s1_cnt", 64'(last_cnt), 64'(1'b1));
        check("lit_s1_e0", last_e0, 64'hBFC0_0000_3333_4444);
        check("lit_s1_e1", last_e1, 64'hBFC0_0004_1111_2222);
        wait_req();
        check("lit_s1_next", 64'(ic_addr), 64'h0000_0000_BFC0_0008);

        // Redirect in IDLE to the upper word of a block.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1004;
        tick();
        redirect_valid = 1'b0;
        check("lit_s2_addr", 64'(ic_addr), 64'h0000_0000_0000_1000);
        pc0 = push_count;
        do_ack(1'b0, 32'h0);
        do_rvalid(64'hAAAA_BBBB_5555_6666);
        wait_push(pc0);
        check("lit_s2_cnt", 64'(last_cnt), 64'(1'b0));
        check("lit_s2_e0", last_e0, 64'h0000_1004_AAAA_BBBB);
        check("lit_s2_e1", last_e1, 64'h0);
        wait_req();
        check("lit_s2_next", 64'(ic_addr), 64'h0000_0000_0000_1008);

        // Queue full for five cycles while entries are held.
        buf_full = 1'b1;
        pc0 = push_count;
        do_ack(1'b0, 32'h0);
        do_rvalid(64'hCCCC_DDDD_EEEE_FFFF);
        repeat (5) tick();
        check("lit_s3_held", 64'(push_count), 64'(pc0));
        buf_full = 1'b0;
        wait_push(pc0);
        check("lit_s3_e0", last_e0, 64'h0000_1008_EEEE_FFFF);
        check("lit_s3_e1", last_e1, 64'h0000_100C_CCCC_DDDD);
        wait_req();
        check("lit_s3_single", 64'(push_count), 64'(pc0 + 1));
        check("lit_s3_next", 64'(ic_addr), 64'h0000_0000_0000_1010);

        // Redirect while waiting; the late response is dropped.
        pc0 = push_count;
        do_ack(1'b0, 32'h0);
        do_redirect(32'h0000_2000);
        repeat (2) tick();
        do_rvalid(64'h9999_8888_7777_6666);
        wait_req();
        check("lit_s4_nopush", 64'(push_count), 64'(pc0));
        check("lit_s4_addr", 64'(ic_addr), 64'h0000_0000_0000_2000);

        // Stray response while requesting is ignored.
        do_rvalid(64'h5555_4444_3333_2222);
        tick();
        check("lit_s5_nopush", 64'(push_count), 64'(pc0));

        // Redirect in the accept cycle.
        do_ack(1'b1, 32'h0000_3000);
        do_rvalid(64'h1234_5678_9ABC_DEF0);
        wait_req();
        check("lit_s6_nopush", 64'(push_count), 64'(pc0));
        check("lit_s6_addr", 64'(ic_addr), 64'h0000_0000_0000_3000);

        // Redirect in the push cycle.
        do_ack(1'b0, 32'h0);
        do_rvalid(64'h0F0F_0F0F_F0F0_F0F0);
        do_redirect(32'h0000_4000);
        wait_req();
        check("lit_s7_nopush", 64'(push_count), 64'(pc0));
        check("lit_s7_addr", 64'(ic_addr), 64'h0000_0000_0000_4000);

        // Redirect while requesting, then fetch across the address wrap.
        do_redirect(32'hFFFF_FFF8);
        check("lit_s8_addr", 64'(ic_addr), 64'h0000_0000_FFFF_FFF8);
        do_ack(1'b0, 32'h0);
        do_rvalid(64'h0123_4567_89AB_CDEF);
        wait_push(pc0);
        check("lit_s8_e0", last_e0, 64'hFFFF_FFF8_89AB_CDEF);
        check("lit_s8_e1", last_e1, 64'hFFFF_FFFC_0123_4567);
        wait_req();
        check("lit_s8_wrap", 64'(ic_addr), 64'h0);

        // Reset mid-request; the late response must not be pushed.
        pc0 = push_count;
        do_ack(1'b0, 32'h0);
        #3;
        reset_n = 1'b0;
        #1;
        check("lit_s9_async_req", 64'(ic_req), 64'(1'b0));
        check("lit_s9_async_addr", 64'(ic_addr), 64'h0000_0000_BFC0_0000);
        tick();
        reset_n   = 1'b1;
        ic_rvalid = 1'b1;
        ic_rdata  = 64'hAAAA_5555_AAAA_5555;
        tick();
        tick();
        ic_rvalid = 1'b0;
        repeat (2) tick();
        check("lit_s9_nopush", 64'(push_count), 64'(pc0));
        check("lit_s9_req", 64'(ic_req), 64'(1'b1));

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset; SHALL be word-aligned.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 redirect_valid  in  1  branch/exception redirect strobe.
REQ-005 redirect_pc  in  32  redirect target, word-aligned.
REQ-006 ic_req  out  1  icache fetch request.
REQ-007 ic_addr  out  32  fetch address, always 8-byte aligned ({pc[31:3],3'b0}).
REQ-008 ic_ack  in  1  icache accepted request this cycle.
REQ-009 ic_rvalid  in  1  response data valid.
REQ-010 ic_rdata  in  64  [31:0] = word at ic_addr, [63:32] = word at ic_addr+4.
REQ-011 buf_ins_enable  out  1  push to downstream instruction queue.
REQ-012 buf_new_count  out  1  elements pushed minus one (0 = one, 1 = two).
REQ-013 buf_elements  out  2 x fetch_entry_t  pushed entries, element 0 oldest.
REQ-014 buf_full  in  1  queue cannot accept a push this cycle.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, PUSH; at most one icache request outstanding.
REQ-016 IDLE -> REQ unconditionally; ic_req and buf_ins_enable SHALL be 0 in IDLE.
REQ-017 REQ: ic_req=1; ic_ack=1 -> WAIT; ic_addr may change while ic_req=1 and ic_ack=0.
REQ-018 WAIT: ic_rvalid=1 with discard=0 -> capture rdata and pc into hold registers, -> PUSH.
REQ-019 PUSH: buf_ins_enable = ~buf_full & ~redirect_valid; on push pc advances, -> REQ same cycle; buf_full=1 -> stay in PUSH, data held.
REQ-020 Entry count: pc[2]=0 -> two entries {pc,rdata[31:0]},{pc+4,rdata[63:32]}, buf_new_count=1, next pc=pc+8; pc[2]=1 -> one entry {pc,rdata[63:32]} in element 0, buf_new_count=0, next pc=pc+4.
REQ-021 Unused element 1 SHALL be driven to zero when buf_new_count=0.
REQ-022 Redirect in IDLE/REQ (no ack): pc <= redirect_pc, state -> REQ.
REQ-023 Redirect in REQ with ic_ack: pc <= redirect_pc, -> WAIT with discard=1.
REQ-024 Redirect in WAIT without ic_rvalid: pc <= redirect_pc, discard <= 1, stay WAIT.
REQ-025 WAIT with ic_rvalid and (discard=1 or redirect_valid): data dropped, discard <= 0, -> REQ; redirect_pc applied if redirect_valid.
REQ-026 Redirect in PUSH: held data dropped, no push, pc <= redirect_pc, -> REQ.
REQ-027 ic_rvalid outside WAIT SHALL be ignored.
REQ-028 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFF8 + 8 wraps to 0.
REQ-029 Latency: ic_rvalid cycle N -> buf_ins_enable earliest cycle N+1; ic_ack-to-next-ic_req minimum 2 cycles.

Reset
REQ-030 reset_n low SHALL asynchronously set state=IDLE, pc=RESET_PC, discard=0, hold registers=0.
REQ-031 During reset ic_req=0, buf_ins_enable=0, buf_new_count=0, buf_elements=0, ic_addr={RESET_PC[31:3],3'b0}.
REQ-032 Reset mid-request SHALL abandon the outstanding request; late ic_rvalid after reset is ignored per REQ-027.

Structure
REQ-033 Package fetch_pkg SHALL hold fetch_entry_t {pc[31:0], instr[31:0]}, state enum fetch_state_e, FETCH_WIDTH=2.
REQ-034 Single module, no sub-modules; fetch_entry_t shared with the instruction queue instantiation.

Verification
REQ-035 Reset, RESET_PC=32'hBFC0_0000, ack/rvalid 1 cycle later each -> push two entries pcs BFC0_0000/BFC0_0004, next ic_addr BFC0_0008.
REQ-036 redirect_pc=32'h0000_1004 in IDLE -> ic_addr 0000_1000; response -> one entry pc 0000_1004 instr=rdata[63:32], new_count=0; next ic_addr 0000_1008.
REQ-037 buf_full=1 for 5 cycles in PUSH -> buf_ins_enable=0, elements stable; buf_full drop -> single push, then ic_req.
REQ-038 Redirect to 32'h0000_2000 in WAIT, rvalid 3 cycles later -> data dropped, no push, next ic_addr 0000_2000.
REQ-039 Redirect coincident with ic_ack -> following rvalid dropped; redirect coincident with push cycle -> no push.
REQ-040 pc=32'hFFFF_FFF8 fetch -> entries FFFF_FFF8/FFFF_FFFC, next ic_addr 0000_0000.
